// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex display driver: active-low glyphs (bit0=a .. bit6=g),
// the blank pattern and the frame-loader FSM encoding.
package hex_disp_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h18;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {
    IDLE   = 1'b0,
    DECODE = 1'b1
  } state_t;

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational nibble -> active-low 7-segment glyph lookup.
module hex_glyph_rom
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_BLANK;
    case (nibble)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// Multi-digit hex display driver: captures a frame, decodes one digit per cycle (MSD first)
// through a shared glyph ROM. Define HEX_DISP_BLINK_EN to build the per-digit blink logic.
module hex_display_driver
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_value,
  input  logic [NUM_DIGITS-1:0]   in_blank_mask,
  input  logic [NUM_DIGITS-1:0]   in_blink_mask,
  input  logic                    in_lz_suppress,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    update_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t state_reg, state_next;

  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] value_reg;
  logic [NUM_DIGITS-1:0]   blank_reg;
  logic                    lz_reg;
  logic                    seen_nz_reg;
  logic                    update_done_reg;
  logic [6:0]              seg_reg [NUM_DIGITS];

  logic       accept;
  logic       last_digit;
  logic [3:0] nibble;
  logic [6:0] glyph;
  logic [6:0] digit_pat;

  assign accept     = (state_reg == IDLE) && in_valid;
  assign last_digit = (idx_reg == IDX_W'(0));
  assign in_ready   = (state_reg == IDLE);
  assign update_done = update_done_reg;

  assign nibble = value_reg[4*idx_reg +: 4];

  hex_glyph_rom u_glyph_rom (
    .nibble (nibble),
    .glyph  (glyph)
  );

  // Leading-zero test uses seen_nz from the more significant digits only.
  always_comb begin
    digit_pat = glyph;
    if (blank_reg[idx_reg]) begin
      digit_pat = SEG_BLANK;
    end else if (lz_reg && !seen_nz_reg && (nibble == 4'h0) && !last_digit) begin
      digit_pat = SEG_BLANK;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = DECODE;
      DECODE:  if (last_digit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_reg         <= '0;
      value_reg       <= '0;
      blank_reg       <= '0;
      lz_reg          <= 1'b0;
      seen_nz_reg     <= 1'b0;
      update_done_reg <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_reg[i] <= SEG_BLANK;
      end
    end else begin
      update_done_reg <= (state_reg == DECODE) && last_digit;
      if (accept) begin
        value_reg   <= in_value;
        blank_reg   <= in_blank_mask;
        lz_reg      <= in_lz_suppress;
        idx_reg     <= IDX_W'(NUM_DIGITS - 1);
        seen_nz_reg <= 1'b0;
      end else if (state_reg == DECODE) begin
        seg_reg[idx_reg] <= digit_pat;
        idx_reg          <= idx_reg - IDX_W'(1);
        seen_nz_reg      <= seen_nz_reg | (nibble != 4'h0);
      end
    end
  end

`ifdef HEX_DISP_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CNT_W-1:0]      blink_cnt_reg;
  logic                  blink_phase_reg;
  logic [NUM_DIGITS-1:0] blink_mask_reg;

  // Free-running: frame loads never disturb the blink cadence.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      blink_mask_reg  <= '0;
    end else begin
      if (blink_cnt_reg == CNT_W'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + CNT_W'(1);
      end
      if (accept) begin
        blink_mask_reg <= in_blink_mask;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_segs
    assign segs[7*gi +: 7] = seg_reg[gi] | {7{blink_mask_reg[gi] & blink_phase_reg}};
  end
`else
  logic unused_blink;
  localparam int unused_blink_div = BLINK_DIV;
  assign unused_blink = ^in_blink_mask;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_segs
    assign segs[7*gi +: 7] = seg_reg[gi];
  end
`endif

endmodule

// File: tb/tb_hex_display_driver.sv
// Self-checking bench for hex_display_driver (NUM_DIGITS=4, BLINK_DIV=4) using a frame scoreboard.
module tb_hex_display_driver;

  localparam int ND = 4;

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_value;
  logic [3:0]    in_blank_mask;
  logic [3:0]    in_blink_mask;
  logic          in_lz_suppress;
  logic [27:0]   segs;
  logic          update_done;

  hex_display_driver #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (4)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_value       (in_value),
    .in_blank_mask  (in_blank_mask),
    .in_blink_mask  (in_blink_mask),
    .in_lz_suppress (in_lz_suppress),
    .segs           (segs),
    .update_done    (update_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] segs;
    logic [27:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   checks_cnt  = 0;
  int   errors_cnt  = 0;
  int   done_cnt    = 0;
  int   frames_sent = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] ref_segs(input logic [15:0] v, input logic [3:0] b, input logic lz);
    logic [27:0] r;
    logic        seen;
    logic [3:0]  nib;
    r    = '0;
    seen = 1'b0;
    for (int i = ND - 1; i >= 0; i--) begin
      nib = v[4*i +: 4];
      if (b[i])                                 r[7*i +: 7] = 7'h7F;
      else if (lz && !seen && nib == 0 && i != 0) r[7*i +: 7] = 7'h7F;
      else                                      r[7*i +: 7] = ref_glyph(nib);
      if (nib != 0) seen = 1'b1;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn && update_done === 1'b1) begin
      exp_t e;
      done_cnt++;
      check_eq("sb_nonempty", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_eq("frame_segs", segs | e.mask, e.segs | e.mask);
        $display("frame done: segs=%h expected=%h", segs, e.segs);
      end
    end
  end

  task automatic send(input logic [15:0] v, input logic [3:0] b, input logic [3:0] k, input logic lz);
    exp_t e;
    int   n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", in_ready, 1);
    in_valid       = 1'b1;
    in_value       = v;
    in_blank_mask  = b;
    in_blink_mask  = k;
    in_lz_suppress = lz;
    e.segs = ref_segs(v, b, lz);
    e.mask = '0;
`ifdef HEX_DISP_BLINK_EN
    for (int i = 0; i < ND; i++) if (k[i]) e.mask[7*i +: 7] = 7'h7F;
`endif
    sb_q.push_back(e);
    frames_sent++;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_busy();
    for (int k = 0; k < ND; k++) begin
      check_eq("busy_ready_low", in_ready, 0);
      @(negedge clk);
    end
    check_eq("ready_after_frame", in_ready, 1);
    check_eq("done_after_frame", update_done, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (update_done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_timeout", update_done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  d0   [16];
    logic [20:0] rest [16];
    int          first;
    int          base_done;
    logic        ok;

    resetn = 1'b0;
    in_valid = 1'b0;
    in_value = '0;
    in_blank_mask = '0;
    in_blink_mask = '0;
    in_lz_suppress = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_segs", segs, {4{7'h7F}});
    check_eq("reset_done", update_done, 0);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("reset_ready", in_ready, 1);

    send(16'h00A5, 4'b0000, 4'b0000, 1'b0);
    check_busy();
    check_eq("frame_a5_spec", segs, {7'h40, 7'h40, 7'h08, 7'h12});
    @(negedge clk);
    check_eq("done_one_cycle", update_done, 0);

    send(16'h00A5, 4'b0000, 4'b0000, 1'b1);
    wait_done();
    check_eq("frame_a5_lz_spec", segs, {7'h7F, 7'h7F, 7'h08, 7'h12});

    send(16'h0000, 4'b0000, 4'b0000, 1'b1);
    wait_done();
    check_eq("frame_zero_lz_spec", segs, {7'h7F, 7'h7F, 7'h7F, 7'h40});

    send(16'h1234, 4'b0010, 4'b0000, 1'b0);
    wait_done();
    check_eq("frame_1234_blank", segs, {7'h79, 7'h24, 7'h7F, 7'h19});
    send(16'hFEDC, 4'b0000, 4'b0000, 1'b0);
    check_busy();
    check_eq("frame_fedc_b2b", segs, {7'h0E, 7'h06, 7'h21, 7'h46});

    for (int r = 0; r < 6; r++) begin
      send(16'($urandom), 4'($urandom), 4'b0000, 1'($urandom));
      wait_done();
    end
    send(16'h0070, 4'b0100, 4'b0000, 1'b1);
    wait_done();

`ifdef HEX_DISP_BLINK_EN
    send(16'h1234, 4'b0000, 4'b0001, 1'b0);
    wait_done();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      d0[k]   = segs[6:0];
      rest[k] = segs[27:7];
    end
    ok = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (d0[k] != 7'h19 && d0[k] != 7'h7F) ok = 1'b0;
      if (rest[k] != {7'h79, 7'h24, 7'h30}) ok = 1'b0;
    end
    check_eq("blink_values", ok, 1);
    first = -1;
    for (int k = 1; k <= 8; k++) if (first < 0 && d0[k] != d0[k-1]) first = k;
    check_eq("blink_edge_found", first >= 1, 1);
    if (first >= 1) begin
      ok = 1'b1;
      for (int k = 1; k < 4; k++) begin
        if (d0[first+k] != d0[first]) ok = 1'b0;
        if (d0[first+4+k] != d0[first+4]) ok = 1'b0;
      end
      check_eq("blink_half_period", ok, 1);
      check_eq("blink_toggle", d0[first+4] != d0[first], 1);
    end
`endif

    send(16'h1234, 4'b0000, 4'b0000, 1'b0);
    @(negedge clk);
    base_done = done_cnt;
    resetn = 1'b0;
    void'(sb_q.pop_back());
    frames_sent--;
    #1;
    check_eq("midreset_segs", segs, {4{7'h7F}});
    check_eq("midreset_done", update_done, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_eq("midreset_ready", in_ready, 1);
    repeat (8) @(negedge clk);
    check_eq("midreset_no_done", done_cnt, base_done);
    check_eq("midreset_segs_hold", segs, {4{7'h7F}});

    check_eq("done_count", done_cnt, frames_sent);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule

// File: doc/hex_display_driver.md
# hex_display_driver

Parametrised multi-digit hexadecimal display driver for the board's active-low 7-segment displays. It accepts a whole NUM_DIGITS-nibble value through a valid/ready handshake, then decodes it one digit per cycle through a single shared glyph decoder. It applies per-digit blanking, optional leading-zero suppression and optional per-digit blinking, and holds every digit's segment pattern in registers. It sits between datapath or status logic and the HEX output pins.

## Interface
- NUM_DIGITS, 6, number of digits driven (1..8)
- BLINK_DIV, 25_000_000, clock cycles per blink half-period (≥2)
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  new frame offered
- in_ready  out  1  driver can accept a frame
- in_value  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is least significant
- in_blank_mask  in  NUM_DIGITS  1 forces digit i blank
- in_blink_mask  in  NUM_DIGITS  1 makes digit i blink
- in_lz_suppress  in  1  enables leading-zero suppression
- segs  out  7*NUM_DIGITS  digit i at bits [7i+6:7i]; bit0=a … bit6=g; active-low
- update_done  out  1  one-cycle pulse after a frame is fully written

## Operation
- Segment encoding is active-low, so 0 lights a segment and blank is 7'h7F.
- Glyphs: standard 0–9, A, b, C, d, E, F. 6 includes segment a. 7 lights only a, b, c. 9 omits segment d.
- FSM states:
  - IDLE: in_ready=1. On in_valid, capture value, masks and lz flag into shadow registers, set idx=NUM_DIGITS-1, clear seen_nz, go to DECODE.
  - DECODE: in_ready=0. Each cycle, write digit idx's register, then decrement idx. After idx=0 is written, return to IDLE.
- Digit rules, in priority order:
  - blank_mask bit set → 7'h7F.
  - lz_suppress set, seen_nz clear, nibble=0 and idx≠0 → 7'h7F.
  - Otherwise the glyph is written.
- seen_nz is set by any nonzero nibble, whether or not that digit is masked. Digit 0 is never suppressed by leading-zero logic.
- Blink: a free-running counter runs 0..BLINK_DIV-1 and toggles blink_phase on wrap.
  - The output is the stored pattern OR'd with all-ones when the digit's registered blink bit and blink_phase are both 1.
  - The blink counter is never reset by frame loads.
- Digits not yet rewritten during DECODE keep their previous frame's value.
- in_valid while in_ready=0 is ignored; the source must hold in_valid until the handshake completes.

## Timing
- Accept edge E0 (in_valid & in_ready).
- Digit NUM_DIGITS-1 updates at E1; digit 0 updates at E(NUM_DIGITS).
- At E(NUM_DIGITS): state returns to IDLE, so in_ready is high in the following cycle. update_done is registered high for exactly that cycle.
- Back-to-back frames: the next accept can occur in the same cycle update_done is high. Throughput is one frame per NUM_DIGITS+1 cycles.
- Reset values:
  - segs all 7'h7F; in_ready=1 once resetn is released.
  - update_done=0; state IDLE.
  - blink counter 0; blink_phase 0; stored blink mask 0.
- Reset asserted mid-DECODE blanks all digits immediately and discards the partial frame.

## Configuration
- HEX_DISP_BLINK_EN defined: blink counter, blink_phase and stored blink mask are present and behave as above.
- HEX_DISP_BLINK_EN undefined: none of that logic exists. in_blink_mask remains a port but is ignored, and segs equals the stored patterns. BLINK_DIV is unused.

## Structure
- hex_disp_pkg holds:
  - glyph constants GLYPH_0..GLYPH_F
  - SEG_BLANK = 7'h7F
  - FSM state encoding (IDLE, DECODE)
- Sub-module hex_glyph_rom: combinational 4-bit → 7-bit active-low glyph lookup, instanced once and time-shared across digits.

## Test plan
- NUM_DIGITS=4, lz off, value 16'h00A5 → after 4 DECODE cycles, segs = {7'h40, 7'h40, 7'h08, 7'h12}; update_done pulses once; in_ready=0 for exactly 4 cycles.
- Same frame with lz on → digits 3,2 = 7'h7F; digit1 = 7'h08; digit0 = 7'h12.
- Value 16'h0000 with lz on → digits 3..1 = 7'h7F; digit0 = 7'h40.
- Value 16'h1234 with blank_mask 4'b0010 → digit1 = 7'h7F; others show 1, 2, 4. Then a back-to-back frame 16'hFEDC accepted in the update_done cycle → digits show F, E, d, C.
- BLINK_EN, BLINK_DIV=4, blink_mask 4'b0001 → digit0 alternates glyph/7'h7F every 4 cycles; other digits stay steady.
- resetn pulsed low mid-DECODE → segs = all 7'h7F immediately, update_done stays 0, and in_ready=1 after release.
